// File: rtl/mbist_pkg.sv
// Shared types for the March C- MBIST controller: FSM states, the March C- element
// table and the data-background generator.
package mbist_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // Each element has one or two ops. An op is either a write or a read, and it uses
  // either the background D or its complement ~D.
  typedef struct packed {
    logic desc;
    logic two_ops;
    logic op0_we;
    logic op0_inv;
    logic op1_we;
    logic op1_inv;
  } elem_t;

  localparam int NUM_ELEMS = 6;
  localparam int MAX_DW    = 64;

  localparam elem_t ELEMS [NUM_ELEMS] = '{
    '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0},  // up:   w D
    '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1},  // up:   r D,  w ~D
    '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0},  // up:   r ~D, w D
    '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1},  // down: r D,  w ~D
    '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0},  // down: r ~D, w D
    '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}   // up:   r D
  };

  function automatic int num_bg(input int dw);
    return $clog2(dw) + 1;
  endfunction

  // Background k > 0 sets bit i of the word to bit (k-1) of the index i.
  function automatic logic [MAX_DW-1:0] bg_pattern(input int k);
    logic [MAX_DW-1:0] p;
    p = '0;
    if (k > 0)
      for (int i = 0; i < MAX_DW; i++) p[i] = ((i >> (k - 1)) & 1) == 1;
    return p;
  endfunction

endpackage

// File: rtl/mbist_rd_check.sv
// Read-compare path. The expected data, address and background of each read are
// carried along with the memory's two-cycle read latency. The block counts
// miscompares and keeps the details of the first one.
module mbist_rd_check #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  chk_valid,
  input  logic [DATA_WIDTH-1:0] chk_data,
  input  logic [ADDR_WIDTH-1:0] chk_addr,
  input  logic [1:0]            chk_bg,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic [1:0]            fail_bg,
  output logic [7:0]            err_count
);

  logic [1:0]            vld;
  logic [DATA_WIDTH-1:0] exp_d [2];
  logic [ADDR_WIDTH-1:0] exp_a [2];
  logic [1:0]            exp_b [2];
  logic                  miscompare;

  assign miscompare = vld[1] && (rdata != exp_d[1]);

  // NOTE: only the valid bits are reset; the data stages are ignored while invalid.
  always_ff @(posedge clk) begin
    exp_d[0] <= chk_data;
    exp_d[1] <= exp_d[0];
    exp_a[0] <= chk_addr;
    exp_a[1] <= exp_a[0];
    exp_b[0] <= chk_bg;
    exp_b[1] <= exp_b[0];
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      vld       <= '0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
      fail_bg   <= '0;
      err_count <= '0;
    end else begin
      vld <= {vld[0], chk_valid};
      if (miscompare) begin
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        if (!fail) begin
          fail      <= 1'b1;
          fail_addr <= exp_a[1];
          fail_data <= rdata;
          fail_bg   <= exp_b[1];
        end
      end
    end
  end

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- MBIST controller. The sequencer issues one op per cycle. wdata is driven
// one cycle ahead of write_read/address. Reads are checked by mbist_rd_check.
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CAPACITY   = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic [1:0]            fail_bg,
  output logic [7:0]            err_count,
  output logic                  write_read,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata
);

  localparam int                    NUM_BG    = num_bg(DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CAPACITY);
  localparam logic [1:0]            LAST_BG   = 2'(NUM_BG - 1);
  localparam logic [2:0]            LAST_ELEM = 3'(NUM_ELEMS - 1);

  state_t                state;
  logic [1:0]            bg, nxt_bg;
  logic [2:0]            elem, nxt_elem;
  logic                  op_idx, nxt_op_idx;
  logic [ADDR_WIDTH-1:0] addr, nxt_addr;
  logic                  drain_cnt;
  logic                  last_issue;
  logic                  cur_we;
  logic [DATA_WIDTH-1:0] cur_data, nxt_data;
  logic                  exp_valid;
  logic [DATA_WIDTH-1:0] exp_data;
  logic [1:0]            exp_bg;
  logic                  accept;

  assign accept = start && (state == IDLE || state == DONE);

  function automatic logic [DATA_WIDTH-1:0] op_data(input logic [1:0] b, input logic [2:0] e,
                                                    input logic oi);
    logic [MAX_DW-1:0] pat;
    logic              inv;
    pat = bg_pattern(int'(b));
    inv = oi ? ELEMS[e].op1_inv : ELEMS[e].op0_inv;
    return pat[DATA_WIDTH-1:0] ^ {DATA_WIDTH{inv}};
  endfunction

  always_comb begin
    // NOTE: every output of this block gets a default first so that no path infers a latch.
    nxt_bg     = bg;
    nxt_elem   = elem;
    nxt_op_idx = 1'b0;
    nxt_addr   = addr;
    last_issue = 1'b0;
    cur_we     = op_idx ? ELEMS[elem].op1_we : ELEMS[elem].op0_we;
    cur_data   = op_data(bg, elem, op_idx);
    if (op_idx != ELEMS[elem].two_ops) begin
      nxt_op_idx = 1'b1;
    end else if (ELEMS[elem].desc ? (addr != '0) : (addr != LAST_ADDR)) begin
      nxt_addr = ELEMS[elem].desc ? addr - 1'b1 : addr + 1'b1;
    end else if (elem != LAST_ELEM) begin
      nxt_elem = elem + 3'd1;
      nxt_addr = ELEMS[nxt_elem].desc ? LAST_ADDR : '0;
    end else if (bg != LAST_BG) begin
      nxt_bg   = bg + 2'd1;
      nxt_elem = '0;
      nxt_addr = '0;
    end else begin
      last_issue = 1'b1;
    end
    nxt_data = op_data(nxt_bg, nxt_elem, nxt_op_idx);
  end

  // NOTE: sequential state uses non-blocking assignments, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      write_read <= 1'b0;
      address    <= '0;
      wdata      <= '0;
      bg         <= '0;
      elem       <= '0;
      op_idx     <= 1'b0;
      addr       <= '0;
      drain_cnt  <= 1'b0;
      exp_valid  <= 1'b0;
      exp_data   <= '0;
      exp_bg     <= '0;
    end else begin
      write_read <= 1'b0;
      address    <= '0;
      exp_valid  <= 1'b0;
      case (state)
        IDLE, DONE: if (start) begin
          state  <= RUN;
          busy   <= 1'b1;
          done   <= 1'b0;
          bg     <= '0;
          elem   <= '0;
          op_idx <= 1'b0;
          addr   <= '0;
          wdata  <= op_data(2'd0, 3'd0, 1'b0);
        end
        RUN: begin
          write_read <= cur_we;
          address    <= addr;
          exp_valid  <= !cur_we;
          exp_data   <= cur_data;
          exp_bg     <= bg;
          bg         <= nxt_bg;
          elem       <= nxt_elem;
          op_idx     <= nxt_op_idx;
          addr       <= nxt_addr;
          wdata      <= nxt_data;
          // The final read reaches the bus during the first DRAIN cycle.
          if (last_issue) begin
            state     <= DRAIN;
            drain_cnt <= 1'b0;
            wdata     <= '0;
          end
        end
        DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mbist_rd_check #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_rd_check (
    .clk       (clk),
    .rst       (rst),
    .clr       (accept),
    .chk_valid (exp_valid),
    .chk_data  (exp_data),
    .chk_addr  (address),
    .chk_bg    (exp_bg),
    .rdata     (rdata),
    .fail      (fail),
    .fail_addr (fail_addr),
    .fail_data (fail_data),
    .fail_bg   (fail_bg),
    .err_count (err_count)
  );

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl. It provides a behavioural memory with injectable faults
// and a March C- reference model written as plain loops over elements and addresses.
module tb_mbist_march_ctrl;
  import mbist_pkg::*;

  localparam int DW     = 8;
  localparam int AW     = 4;
  localparam int CAP    = 15;
  localparam int N      = CAP + 1;
  localparam int NBG    = $clog2(DW) + 1;
  localparam int TOTAL  = NBG * 10 * N + 3;
  localparam int BUDGET = 2000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, fail, write_read;
  logic [AW-1:0] fail_addr, address;
  logic [DW-1:0] fail_data, wdata;
  logic [DW-1:0] rdata;
  logic [1:0]    fail_bg;
  logic [7:0]    err_count;

  int n_checks = 0;
  int n_fail   = 0;

  mbist_march_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CAPACITY(CAP)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .fail(fail),
    .fail_addr(fail_addr), .fail_data(fail_data), .fail_bg(fail_bg), .err_count(err_count),
    .write_read(write_read), .address(address), .wdata(wdata), .rdata(rdata)
  );

  always #5 clk = ~clk;

  // Fault modes: 0 = none, 1 = bit flt_bit of flt_addr stuck at 1, 2 = writes to flt_addr land at flt_addr^1.
  int            flt_mode = 0;
  int            flt_addr = 0;
  int            flt_bit  = 0;
  logic          mem_load = 1'b0;
  logic [DW-1:0] init_mem [N];
  logic [DW-1:0] mem [N];
  logic [DW-1:0] wdata_q, rd_pipe;

  function automatic int phys(input int a);
    return (flt_mode == 2 && a == flt_addr) ? (a ^ 1) : a;
  endfunction

  function automatic logic [DW-1:0] rd_mask(input int a);
    logic [DW-1:0] m;
    m = '0;
    if (flt_mode == 1 && a == flt_addr) m[flt_bit] = 1'b1;
    return m;
  endfunction

  // The memory writes the wdata of the previous cycle when it sees a write address.
  // Read data comes back two cycles after the read address.
  always @(posedge clk) begin
    wdata_q <= wdata;
    rd_pipe <= mem[address] | rd_mask(int'(address));
    rdata   <= rd_pipe;
    if (mem_load) begin
      for (int i = 0; i < N; i++) mem[i] <= init_mem[i];
    end else if (write_read) begin
      mem[phys(int'(address))] <= wdata_q;
    end
  end

  // Reference model: March C- as (direction, op list) per element.
  typedef struct { bit we; int addr; logic [DW-1:0] data; } op_t;
  localparam bit       DESC_E [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam int       NOPS_E [6] = '{1, 2, 2, 2, 2, 1};
  localparam bit [1:0] WE_E   [6] = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00};
  localparam bit [1:0] INV_E  [6] = '{2'b00, 2'b10, 2'b01, 2'b10, 2'b01, 2'b00};

  op_t           ops[$];
  int            ref_err, ref_faddr, ref_fbg;
  bit            ref_fail;
  logic [DW-1:0] ref_fdata;

  task automatic ref_run();
    logic [DW-1:0] m [N];
    logic [DW-1:0] d, v, got;
    int            a;
    ops.delete();
    for (int i = 0; i < N; i++) m[i] = init_mem[i];
    ref_err = 0; ref_fail = 0; ref_faddr = 0; ref_fbg = 0; ref_fdata = '0;
    for (int b = 0; b < NBG; b++) begin
      for (int i = 0; i < DW; i++) d[i] = (b == 0) ? 1'b0 : (((i >> (b - 1)) & 1) == 1);
      for (int e = 0; e < 6; e++)
        for (int s = 0; s < N; s++) begin
          a = DESC_E[e] ? CAP - s : s;
          for (int o = 0; o < NOPS_E[e]; o++) begin
            v = INV_E[e][o] ? ~d : d;
            ops.push_back('{WE_E[e][o], a, v});
            if (WE_E[e][o]) m[phys(a)] = v;
            else begin
              got = m[a] | rd_mask(a);
              if (got !== v) begin
                if (ref_err < 255) ref_err++;
                if (!ref_fail) begin
                  ref_fail = 1; ref_faddr = a; ref_fdata = got; ref_fbg = b;
                end
              end
            end
          end
        end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load_mem();
    @(negedge clk) mem_load = 1'b1;
    @(negedge clk) mem_load = 1'b0;
  endtask

  logic [DW-1:0] wd_seen   [BUDGET+1];
  logic [AW-1:0] addr_seen [BUDGET+1];
  logic          wr_seen   [BUDGET+1];

  // Pulse start, then follow the bus cycle by cycle against the reference op list.
  task automatic run_test(input int pulse_k, output int cycles, output int stream_errs);
    int m_ops;
    m_ops = ops.size();
    stream_errs = 0;
    cycles = -1;
    @(negedge clk) start = 1'b1;
    for (int k = 1; k <= BUDGET; k++) begin
      @(negedge clk);
      wd_seen[k] = wdata; addr_seen[k] = address; wr_seen[k] = write_read;
      if (k - 1 < m_ops && wdata !== ops[k-1].data) stream_errs++;
      if (k >= 2 && k - 2 < m_ops &&
          (write_read !== ops[k-2].we || int'(address) != ops[k-2].addr)) stream_errs++;
      if (done === 1'b1) begin
        if (busy !== 1'b0) stream_errs++;
        cycles = k;
        break;
      end
      if (busy !== 1'b1) stream_errs++;
      start = (k == pulse_k);
    end
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    int mode; int faddr; int fbit;
    bit exp_fail; int exp_addr; int exp_data; int exp_bg; int exp_err;
  } vec_t;

  vec_t vecs [3];
  int   cyc, se;

  initial begin
    vecs[0] = '{0, 0, 0, 1'b0, 0, 0,    0, 0};
    vecs[1] = '{1, 5, 0, 1'b1, 5, 'h01, 0, 12};
    vecs[2] = '{2, 7, 0, 1'b1, 7, 'h00, 0, -1};

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);            check("rst_done", done, 0);
    check("rst_fail", fail, 0);            check("rst_fail_addr", fail_addr, 0);
    check("rst_fail_data", fail_data, 0);  check("rst_fail_bg", fail_bg, 0);
    check("rst_err_count", err_count, 0);  check("rst_write_read", write_read, 0);
    check("rst_address", address, 0);      check("rst_wdata", wdata, 0);
    rst = 1'b0;

    for (int v = 0; v < 3; v++) begin
      flt_mode = vecs[v].mode; flt_addr = vecs[v].faddr; flt_bit = vecs[v].fbit;
      for (int i = 0; i < N; i++) init_mem[i] = '0;
      load_mem();
      ref_run();
      run_test(0, cyc, se);
      check($sformatf("v%0d_cycles", v), cyc, TOTAL);
      check($sformatf("v%0d_op_stream", v), se, 0);
      check($sformatf("v%0d_fail", v), fail, vecs[v].exp_fail);
      check($sformatf("v%0d_fail_vs_model", v), fail, ref_fail);
      check($sformatf("v%0d_err_vs_model", v), err_count, ref_err);
      if (vecs[v].exp_err >= 0) check($sformatf("v%0d_err_count", v), err_count, vecs[v].exp_err);
      if (vecs[v].exp_fail) begin
        check($sformatf("v%0d_fail_addr", v), fail_addr, vecs[v].exp_addr);
        check($sformatf("v%0d_fail_data", v), fail_data, vecs[v].exp_data);
        check($sformatf("v%0d_fail_bg", v), fail_bg, vecs[v].exp_bg);
      end
      if (v == 0) begin
        check("t_wdata_s1", wd_seen[1], 0);
        check("t_we_s2", wr_seen[2], 1);
        check("t_addr_s2", addr_seen[2], 0);
        check("t_e2_last_we", wr_seen[5*N+1], 1);
        check("t_e2_last_addr", addr_seen[5*N+1], CAP);
        check("t_e3_first_we", wr_seen[5*N+2], 0);
        check("t_e3_first_addr", addr_seen[5*N+2], CAP);
      end
    end

    // Reset during the first descending element, with a fault already recorded.
    flt_mode = 1; flt_addr = 5; flt_bit = 0;
    load_mem();
    @(negedge clk) start = 1'b1;
    for (int k = 1; k <= 5*N + 8; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("pre_rst_fail", fail, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_state", 32'(dut.state), 32'(IDLE));
    check("mid_rst_busy", busy, 0);          check("mid_rst_done", done, 0);
    check("mid_rst_fail", fail, 0);          check("mid_rst_err", err_count, 0);
    check("mid_rst_fail_addr", fail_addr, 0); check("mid_rst_fail_data", fail_data, 0);
    check("mid_rst_fail_bg", fail_bg, 0);    check("mid_rst_we", write_read, 0);
    check("mid_rst_addr", address, 0);       check("mid_rst_wdata", wdata, 0);
    rst = 1'b0;
    flt_mode = 0;
    load_mem();
    ref_run();
    run_test(0, cyc, se);
    check("post_rst_cycles", cyc, TOTAL);
    check("post_rst_stream", se, 0);
    check("post_rst_fail", fail, 0);
    check("post_rst_err", err_count, 0);

    // Random faults, random memory contents and a stray start while busy; each run starts from DONE.
    for (int r = 0; r < 4; r++) begin
      flt_mode = $urandom_range(0, 2);
      flt_addr = $urandom_range(0, CAP);
      flt_bit  = $urandom_range(0, DW - 1);
      for (int i = 0; i < N; i++) init_mem[i] = DW'($urandom);
      load_mem();
      ref_run();
      run_test($urandom_range(3, NBG * 10 * N), cyc, se);
      check($sformatf("r%0d_cycles", r), cyc, TOTAL);
      check($sformatf("r%0d_op_stream", r), se, 0);
      check($sformatf("r%0d_fail", r), fail, ref_fail);
      check($sformatf("r%0d_err", r), err_count, ref_err);
      if (ref_fail) begin
        check($sformatf("r%0d_fail_addr", r), fail_addr, ref_faddr);
        check($sformatf("r%0d_fail_data", r), fail_data, ref_fdata);
        check($sformatf("r%0d_fail_bg", r), fail_bg, ref_fbg);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
